byte_bus_sequencer: RTL and testbench
=====================================

BYTE_BUS_SEQUENCER -- requirements
Module: byte_bus_sequencer

Interface
REQ-001 SHALL have parameter BUS_ADDRESS_WIDTH, default 8, the width of the external byte-bus address.
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port request, input, 1, CPU memory access request, sampled in IDLE only.
REQ-005 SHALL have port write, input, 1, 1 = store, 0 = load, sampled with request.
REQ-006 SHALL have port size, input, 2, 0 = byte, 1 = halfword, 2 or 3 = word, sampled with request.
REQ-007 SHALL have port load_unsigned, input, 1, 1 = zero-extend, 0 = sign-extend a byte or halfword load, sampled with request.
REQ-008 SHALL have port address, input, BUS_ADDRESS_WIDTH, base byte address, sampled with request.
REQ-009 SHALL have port write_data, input, 32, store data, little-endian, sampled with request.
REQ-010 SHALL have port read_data, output, 32, extended load result, valid while done = 1.
REQ-011 SHALL have port busy, output, 1, high from the cycle after acceptance through the DONE cycle inclusive.
REQ-012 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-013 SHALL have port bus_address, output, BUS_ADDRESS_WIDTH, external byte address.
REQ-014 SHALL have port bus_write_enable, output, 1, external write strobe; also used as the bus pad output enable.
REQ-015 SHALL have port bus_write_data, output, 8, external write byte.
REQ-016 SHALL have port bus_read_data, input, 8, external read byte.
REQ-017 SHALL have port bus_ready, input, 1, external beat acknowledge.

Function
REQ-018 SHALL implement the states IDLE, TRANSFER and DONE.
REQ-019 SHALL, in IDLE with request = 1, latch write, size, load_unsigned, address and write_data, clear the beat counter, and go to TRANSFER.
REQ-020 SHALL, in IDLE with request = 0, remain in IDLE.
REQ-021 SHALL set the beat count to 1 for byte, 2 for halfword and 4 for word; size 3 SHALL behave as word.
REQ-022 SHALL, in TRANSFER, drive bus_address = (latched address + beat) modulo 2^BUS_ADDRESS_WIDTH; wrap from 0xFF to 0x00 is legal.
REQ-023 SHALL, in TRANSFER on a store, drive bus_write_enable = 1 and bus_write_data = byte[beat] of the latched data, with byte 0 = bits 7:0.
REQ-024 SHALL hold the beat and all bus outputs stable while bus_ready = 0; there is no timeout.
REQ-025 SHALL, on a rising edge with bus_ready = 1 in TRANSFER, complete the beat: on a load, write bus_read_data into byte lane [beat] of the assembly register, then increment beat.
REQ-026 SHALL, on completion of the last beat, go to DONE.
REQ-027 SHALL, in DONE, assert done = 1 for exactly one cycle, then go to IDLE.
REQ-028 SHALL ignore request in TRANSFER and DONE; a request held high from DONE is accepted in the following IDLE cycle.
REQ-029 SHALL, in IDLE and DONE, drive bus_write_enable = 0; bus_address and bus_write_data are don't-care but SHALL be driven 0.
REQ-030 SHALL, for a load, form read_data as: byte = lane 0 extended per load_unsigned; halfword = lanes 1:0 extended; word = lanes 3:0.
REQ-031 SHALL, for a store, drive read_data = 0 in DONE.
REQ-032 SHALL give, with bus_ready tied high, a request-to-done latency of beats + 1 cycles: word request sampled at edge 0 gives done high in the cycle after edge 4.

Reset
REQ-033 SHALL, on reset assertion at any time including mid-transfer, asynchronously force IDLE, clear the beat count and assembly register, and drive every output to 0.
REQ-034 SHALL produce no done pulse for an access aborted by reset and SHALL NOT issue any further bus write.
REQ-035 SHALL accept a new request on the first rising edge after reset deasserts.

Verification
REQ-036 Word load, address 0x10, bus_ready = 1, bus bytes 0x11/0x22/0x33/0x44 -> bus_address 0x10..0x13, done one cycle later, read_data = 0x44332211.
REQ-037 Byte load of 0x80, signed then unsigned -> read_data = 0xFFFFFF80, then 0x00000080; exactly 1 beat each.
REQ-038 Halfword store 0xDEADBEEF to address 0xFF -> writes 0xEF to 0xFF and 0xBE to 0x00; bus_write_enable high for exactly 2 cycles.
REQ-039 Word store with bus_ready low for 3 cycles on beat 1 -> bus outputs held at address base+1 for those cycles; done arrives 3 cycles later than with no wait.
REQ-040 Reset asserted during beat 2 of a word store -> all outputs 0 immediately, no done, no further writes; a following byte load completes normally.
REQ-041 request held high continuously -> back-to-back accesses with exactly one IDLE cycle between each done and the next bus beat.

Source files
------------

// File: rtl/byte_bus_sequencer.sv
// rtl/byte_bus_sequencer.sv - sequences 32-bit CPU loads/stores into byte beats on an 8-bit bus
`timescale 1ns/1ps
module byte_bus_sequencer #(
  parameter int BUS_ADDRESS_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         request,
  input  logic                         write,
  input  logic [1:0]                   size,
  input  logic                         load_unsigned,
  input  logic [BUS_ADDRESS_WIDTH-1:0] address,
  input  logic [31:0]                  write_data,
  output logic [31:0]                  read_data,
  output logic                         busy,
  output logic                         done,
  output logic [BUS_ADDRESS_WIDTH-1:0] bus_address,
  output logic                         bus_write_enable,
  output logic [7:0]                   bus_write_data,
  input  logic [7:0]                   bus_read_data,
  input  logic                         bus_ready
);

  typedef enum logic [1:0] {IDLE, TRANSFER, DONE} state_t;

  state_t                         state_q, state_d;
  logic [1:0]                     beat_q;
  logic                           write_q;
  logic [1:0]                     size_q;
  logic                           unsigned_q;
  logic [BUS_ADDRESS_WIDTH-1:0]   address_q;
  logic [31:0]                    data_q;
  logic [31:0]                    assembly_q;
  logic [1:0]                     last_beat;
  logic [31:0]                    load_result;

  // Index of the final beat: byte=0, halfword=1, word (size 2 or 3)=3.
  always_comb begin
    last_beat = 2'd3;
    if (size_q == 2'd0)      last_beat = 2'd0;
    else if (size_q == 2'd1) last_beat = 2'd1;
  end

  // Extend the assembled lanes to 32 bits according to size and signedness.
  always_comb begin
    load_result = assembly_q;
    if (size_q == 2'd0)
      load_result = {{24{~unsigned_q & assembly_q[7]}}, assembly_q[7:0]};
    else if (size_q == 2'd1)
      load_result = {{16{~unsigned_q & assembly_q[15]}}, assembly_q[15:0]};
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and all outputs; everything is a function of registered state.
  always_comb begin
    state_d          = state_q;
    busy             = 1'b0;
    done             = 1'b0;
    read_data        = 32'd0;
    bus_address      = '0;
    bus_write_enable = 1'b0;
    bus_write_data   = 8'd0;
    case (state_q)
      IDLE: begin
        if (request) state_d = TRANSFER;
      end
      TRANSFER: begin
        busy             = 1'b1;
        bus_address      = address_q + BUS_ADDRESS_WIDTH'(beat_q);
        bus_write_enable = write_q;
        bus_write_data   = write_q ? data_q[{beat_q, 3'b000} +: 8] : 8'd0;
        if (bus_ready && beat_q == last_beat) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        read_data = write_q ? 32'd0 : load_result;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Access latch, beat counter and load assembly register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_q     <= 2'd0;
      write_q    <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      address_q  <= '0;
      data_q     <= 32'd0;
      assembly_q <= 32'd0;
    end else if (state_q == IDLE && request) begin
      beat_q     <= 2'd0;
      write_q    <= write;
      size_q     <= size;
      unsigned_q <= load_unsigned;
      address_q  <= address;
      data_q     <= write_data;
      assembly_q <= 32'd0;
    end else if (state_q == TRANSFER && bus_ready) begin
      if (!write_q) assembly_q[{beat_q, 3'b000} +: 8] <= bus_read_data;
      beat_q <= beat_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_byte_bus_sequencer.sv
// tb/tb_byte_bus_sequencer.sv - randomized and directed checks of byte_bus_sequencer against a transaction model
`timescale 1ns/1ps
module tb_byte_bus_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        request = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        load_unsigned = 1'b0;
  logic [7:0]  address = 8'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        busy;
  logic        done;
  logic [7:0]  bus_address;
  logic        bus_write_enable;
  logic [7:0]  bus_write_data;
  logic [7:0]  bus_read_data = 8'd0;
  logic        bus_ready = 1'b0;

  byte_bus_sequencer #(.BUS_ADDRESS_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .request(request), .write(write), .size(size),
    .load_unsigned(load_unsigned), .address(address), .write_data(write_data),
    .read_data(read_data), .busy(busy), .done(done), .bus_address(bus_address),
    .bus_write_enable(bus_write_enable), .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data), .bus_ready(bus_ready)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // transaction model: phase 0 = waiting, 1 = moving bytes, 2 = completion cycle
  int          m_phase = 0;
  int          m_pos, m_beats;
  bit          m_write, m_unsigned;
  int          m_base;
  logic [31:0] m_data, m_result;
  longint      m_val;

  // observations gathered for the directed literal checks
  logic [7:0]  obs_addr[$];
  logic [7:0]  obs_wd[$];
  logic [7:0]  trace_addr[$];
  int          we_cycles = 0;
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  logic [31:0] last_rd = 32'd0;
  logic [31:0] busy_hist = 32'd0;
  logic [31:0] done_hist = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    case (m_phase)
      0: begin
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle done", 32'(done), 32'd0);
        chk("idle bus_address", 32'(bus_address), 32'd0);
        chk("idle bus_write_enable", 32'(bus_write_enable), 32'd0);
        chk("idle bus_write_data", 32'(bus_write_data), 32'd0);
        chk("idle read_data", read_data, 32'd0);
      end
      1: begin
        chk("xfer busy", 32'(busy), 32'd1);
        chk("xfer done", 32'(done), 32'd0);
        chk("xfer bus_address", 32'(bus_address), 32'((m_base + m_pos) % 256));
        chk("xfer bus_write_enable", 32'(bus_write_enable), 32'(m_write));
        if (m_write)
          chk("xfer bus_write_data", 32'(bus_write_data), (m_data >> (8 * m_pos)) & 32'hFF);
      end
      default: begin
        chk("done busy", 32'(busy), 32'd1);
        chk("done done", 32'(done), 32'd1);
        chk("done bus_address", 32'(bus_address), 32'd0);
        chk("done bus_write_enable", 32'(bus_write_enable), 32'd0);
        chk("done bus_write_data", 32'(bus_write_data), 32'd0);
        chk("done read_data", read_data, m_write ? 32'd0 : m_result);
      end
    endcase
  endtask

  task automatic model_step(input bit req, input bit wr, input logic [1:0] sz, input bit uns,
                            input logic [7:0] addr, input logic [31:0] wd, input bit rdy,
                            input logic [7:0] rb);
    longint v;
    case (m_phase)
      0: if (req) begin
        m_phase = 1; m_pos = 0; m_write = wr; m_unsigned = uns;
        m_beats = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        m_base = int'(addr); m_data = wd; m_val = 0;
      end
      1: if (rdy) begin
        if (!m_write) m_val = m_val + (longint'(rb) << (8 * m_pos));
        m_pos++;
        if (m_pos == m_beats) begin
          m_phase = 2;
          v = m_val;
          if (!m_unsigned && m_beats < 4 && v >= (longint'(1) << (8 * m_beats - 1)))
            v = v - (longint'(1) << (8 * m_beats)) + (longint'(1) << 32);
          m_result = v[31:0];
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  // One clock: check outputs mid-cycle, record, drive inputs, advance the model at the edge.
  task automatic cycle(input bit req, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [7:0] addr, input logic [31:0] wd, input bit rdy,
                       input logic [7:0] rb);
    @(negedge clock);
    check_outputs();
    if (bus_write_enable) we_cycles++;
    if (busy && !done) begin
      trace_addr.push_back(bus_address);
      if (rdy) begin
        obs_addr.push_back(bus_address);
        obs_wd.push_back(bus_write_data);
      end
    end
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
      last_rd = read_data;
    end
    busy_hist = {busy_hist[30:0], busy};
    done_hist = {done_hist[30:0], done};
    request = req; write = wr; size = sz; load_unsigned = uns;
    address = addr; write_data = wd; bus_ready = rdy; bus_read_data = rb;
    @(posedge clock);
    model_step(req, wr, sz, uns, addr, wd, rdy, rb);
    cyc++;
  endtask

  // Assert reset part way through a cycle, check outputs drop at once, release after the next edge.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    m_phase = 0;
    check_outputs();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_access(input bit wr, input logic [1:0] sz, input bit uns,
                            input logic [7:0] addr, input logic [31:0] wd,
                            input logic [31:0] rbytes, input int wait_beat, input int wait_n,
                            output int lat);
    int c0, d0, waited, idx;
    bit rdy;
    obs_addr.delete(); obs_wd.delete(); trace_addr.delete();
    c0 = cyc; d0 = done_cnt; waited = 0; lat = -1;
    cycle(1'b1, wr, sz, uns, addr, wd, 1'b0, 8'h00);
    for (int i = 0; i < 40 && done_cnt == d0; i++) begin
      rdy = 1'b1;
      if (obs_addr.size() == wait_beat && waited < wait_n) begin
        rdy = 1'b0;
        waited++;
      end
      idx = obs_addr.size() & 3;
      cycle(1'b0, wr, sz, uns, addr, wd, rdy, rbytes[8 * idx +: 8]);
    end
    if (done_cnt == d0) chk("access timeout", 32'd0, 32'd1);
    else lat = last_done_cyc - c0;
  endtask

  initial begin
    int lat, lat_nowait, held, d_before;
    bit rq, wr, un, rdy;
    logic [1:0] sz;
    logic [7:0] ad, rb;
    logic [31:0] wd;

    #12;
    reset = 1'b0;
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 32'd0, 1'b0, 8'h00);

    // word load from 0x10
    run_access(1'b0, 2'd2, 1'b0, 8'h10, 32'd0, 32'h44332211, 9, 0, lat);
    chk("wl beats", obs_addr.size(), 32'd4);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++)
      chk("wl address", 32'(obs_addr[i]), 32'h10 + 32'(i));
    chk("wl read_data", last_rd, 32'h44332211);
    chk("wl latency", 32'(lat), 32'd5);

    // byte load 0x80 signed then unsigned
    run_access(1'b0, 2'd0, 1'b0, 8'h05, 32'd0, 32'h00000080, 9, 0, lat);
    chk("bl signed read_data", last_rd, 32'hFFFFFF80);
    chk("bl signed beats", obs_addr.size(), 32'd1);
    run_access(1'b0, 2'd0, 1'b1, 8'h05, 32'd0, 32'h00000080, 9, 0, lat);
    chk("bl unsigned read_data", last_rd, 32'h00000080);
    chk("bl unsigned beats", obs_addr.size(), 32'd1);
    chk("bl latency", 32'(lat), 32'd2);

    // halfword store wrapping 0xFF -> 0x00
    we_cycles = 0;
    run_access(1'b1, 2'd1, 1'b0, 8'hFF, 32'hDEADBEEF, 32'd0, 9, 0, lat);
    chk("hs beats", obs_addr.size(), 32'd2);
    if (obs_addr.size() == 2) begin
      chk("hs addr0", 32'(obs_addr[0]), 32'hFF);
      chk("hs data0", 32'(obs_wd[0]), 32'hEF);
      chk("hs addr1", 32'(obs_addr[1]), 32'h00);
      chk("hs data1", 32'(obs_wd[1]), 32'hBE);
    end
    chk("hs write cycles", 32'(we_cycles), 32'd2);
    chk("hs read_data", last_rd, 32'd0);

    // word store, with and without 3 wait cycles on beat 1
    run_access(1'b1, 2'd3, 1'b0, 8'h20, 32'h01020304, 32'd0, 9, 0, lat_nowait);
    chk("ws latency", 32'(lat_nowait), 32'd5);
    run_access(1'b1, 2'd2, 1'b0, 8'h20, 32'h01020304, 32'd0, 1, 3, lat);
    chk("ws wait latency", 32'(lat), 32'd8);
    held = 0;
    foreach (trace_addr[i]) if (trace_addr[i] == 8'h21) held++;
    chk("ws held cycles", 32'(held), 32'd4);

    // reset during beat 2 of a word store
    cycle(1'b1, 1'b1, 2'd2, 1'b0, 8'h40, 32'hCAFEF00D, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 2'd2, 1'b0, 8'h40, 32'hCAFEF00D, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 2'd2, 1'b0, 8'h40, 32'hCAFEF00D, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 2'd2, 1'b0, 8'h40, 32'hCAFEF00D, 1'b0, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    m_phase = 0;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst bus_address", 32'(bus_address), 32'd0);
    chk("rst bus_write_enable", 32'(bus_write_enable), 32'd0);
    chk("rst bus_write_data", 32'(bus_write_data), 32'd0);
    chk("rst read_data", read_data, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    we_cycles = 0;
    d_before = done_cnt;
    run_access(1'b0, 2'd0, 1'b0, 8'h41, 32'd0, 32'h0000007F, 9, 0, lat);
    chk("post-rst write cycles", 32'(we_cycles), 32'd0);
    chk("post-rst done count", 32'(done_cnt - d_before), 32'd1);
    chk("post-rst read_data", last_rd, 32'h0000007F);
    chk("post-rst latency", 32'(lat), 32'd2);

    // request held high: byte loads back to back
    for (int i = 0; i < 9; i++)
      cycle(1'b1, 1'b0, 2'd0, 1'b1, 8'h60 + 8'(i), 32'd0, 1'b1, 8'(i));
    chk("b2b busy pattern", busy_hist & 32'h1FF, 32'b011011011);
    chk("b2b done pattern", done_hist & 32'h1FF, 32'b001001001);

    // randomized traffic, occasional reset mid-cycle
    for (int i = 0; i < 4000; i++) begin
      rq = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      ad = 8'($urandom);
      wd = $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      rb = 8'($urandom);
      cycle(rq, wr, sz, un, ad, wd, rdy, rb);
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
